// File: rtl/reg_text_sequencer.sv
// Register text sequencer: turns a frozen register-file snapshot into
// "R<idx>: <hex>" character draw requests over a valid/ready handshake.
//
// Ports:
//   clock, resetn         - clock, async active-low reset
//   reg_flat              - register file, R[i] = reg_flat[i*DATA_W +: DATA_W]
//   start                 - request one refresh pass (ignored while busy)
//   char_valid/char_ready - request handshake to the plotter
//   char_code/col/row     - glyph code, column in line, row (= reg index)
//   busy                  - pass in progress
//   frame_done            - one-cycle pulse at end of pass
module reg_text_sequencer #(
  parameter int NUM_REGS       = 8,
  parameter int DATA_W         = 16,
  parameter int CODE_R         = 52,
  parameter int CODE_COLON     = 53,
  parameter int CODE_SPACE     = 63,
  parameter int SKIP_UNCHANGED = 1,
  localparam int ROW_W =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REGS*DATA_W-1:0] reg_flat,
  input  logic                       start,
  output logic                       char_valid,
  input  logic                       char_ready,
  output logic [7:0]                 char_code,
  output logic [4:0]                 char_col,
  output logic [ROW_W-1:0]           char_row,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int LINE_LEN = 4 + DATA_W / 4;
  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(NUM_REGS - 1);
  localparam logic [4:0] LAST_COL =
    5'(LINE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_t;

  state_t            state_q;
  logic [ROW_W-1:0]  row_q;
  logic [4:0]        col_q;
  logic              first_q;
  logic [DATA_W-1:0] snap_q [NUM_REGS];
  logic [DATA_W-1:0] last_q [NUM_REGS];

  // Glyph for column c of line r; value nibbles are MSB first.
  function automatic logic [7:0] glyph(
    input logic [ROW_W-1:0]  r,
    input logic [4:0]        c,
    input logic [DATA_W-1:0] v
  );
    logic [DATA_W-1:0] sh;
    glyph = 8'd0;
    sh    = '0;
    unique case (1'b1)
      (c == 5'd0): glyph = 8'(CODE_R);
      (c == 5'd1): glyph = 8'(r);
      (c == 5'd2): glyph = 8'(CODE_COLON);
      (c == 5'd3): glyph = 8'(CODE_SPACE);
      default: begin
        sh    = v >> (4 * (LINE_LEN - 1 - int'(c)));
        glyph = {4'd0, sh[3:0]};
      end
    endcase
  endfunction

  logic skip_row;
  assign skip_row = (SKIP_UNCHANGED != 0) && !first_q &&
                    (snap_q[row_q] == last_q[row_q]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      first_q    <= 1'b1;
      char_valid <= 1'b0;
      char_code  <= '0;
      char_col   <= '0;
      char_row   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        snap_q[i] <= '0;
        last_q[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            for (int i = 0; i < NUM_REGS; i++)
              snap_q[i] <= reg_flat[i*DATA_W +: DATA_W];
            busy    <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (skip_row) begin
            if (row_q == LAST_ROW) begin
              state_q    <= DONE;
              frame_done <= 1'b1;
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end else begin
            state_q    <= EMIT;
            col_q      <= '0;
            char_valid <= 1'b1;
            char_code  <= glyph(row_q, 5'd0,
                                snap_q[row_q]);
            char_col   <= '0;
            char_row   <= row_q;
          end
        end
        EMIT: begin
          if (char_ready) begin
            if (col_q != LAST_COL) begin
              col_q     <= col_q + 5'd1;
              char_col  <= col_q + 5'd1;
              char_code <= glyph(row_q, col_q + 5'd1,
                                 snap_q[row_q]);
            end else begin
              char_valid    <= 1'b0;
              last_q[row_q] <= snap_q[row_q];
              if (row_q == LAST_ROW) begin
                state_q    <= DONE;
                frame_done <= 1'b1;
              end else begin
                row_q   <= row_q + ROW_W'(1);
                state_q <= SCAN;
              end
            end
          end
        end
        DONE: begin
          busy    <= 1'b0;
          first_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_text_sequencer.sv
// Scoreboard bench for reg_text_sequencer: directed passes with
// expected requests queued up front and checked by a monitor.
module tb_reg_text_sequencer;

  typedef struct packed {
    logic [7:0] code;
    logic [4:0] col;
    logic [2:0] row;
  } exp_t;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [127:0] reg_flat = '0;
  logic         start = 1'b0;
  logic         char_valid;
  logic         char_ready = 1'b1;
  logic [7:0]   char_code;
  logic [4:0]   char_col;
  logic [2:0]   char_row;
  logic         busy;
  logic         frame_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_xfer  = 0;
  int   n_fd    = 0;
  exp_t exp_q[$];

  bit   bp_en = 1'b0;
  int   stall_left = 0;

  reg_text_sequencer dut (
    .clock      (clock),
    .resetn     (resetn),
    .reg_flat   (reg_flat),
    .start      (start),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_code  (char_code),
    .char_col   (char_col),
    .char_row   (char_row),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Monitor: a transfer is decided by the values seen here and
  // completes on the following rising edge.
  exp_t cur, prev;
  bit   prev_stall = 1'b0;
  always @(negedge clock) begin
    cur = '{char_code, char_col, char_row};
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold", {char_valid, 16'(cur)},
            {1'b1, 16'(prev)});
      end
      if (frame_done) n_fd++;
      if (char_valid && char_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 16'(cur), 16'hffff);
        end else begin
          chk("xfer", 16'(cur), 16'(exp_q.pop_front()));
        end
      end
      prev_stall = char_valid && !char_ready;
      prev = cur;
    end
  end

  // Backpressure: ready low for 0-5 cycles, then high for one.
  always begin
    @(posedge clock);
    #1;
    if (bp_en) begin
      if (stall_left > 0) begin
        char_ready = 1'b0;
        stall_left--;
      end else begin
        char_ready = 1'b1;
        stall_left = $urandom_range(0, 5);
      end
    end
  end

  task automatic push_codes(input logic [2:0] r,
                            input int c[8]);
    for (int k = 0; k < 8; k++)
      exp_q.push_back(exp_t'{8'(c[k]), 5'(k), r});
  endtask

  task automatic push_line(input logic [2:0] r,
                           input logic [15:0] v);
    exp_q.push_back(exp_t'{8'd52, 5'd0, r});
    exp_q.push_back(exp_t'{{5'd0, r}, 5'd1, r});
    exp_q.push_back(exp_t'{8'd53, 5'd2, r});
    exp_q.push_back(exp_t'{8'd63, 5'd3, r});
    for (int k = 0; k < 4; k++)
      exp_q.push_back(
        exp_t'{{4'd0, v[15-4*k -: 4]}, 5'(4 + k), r});
  endtask

  task automatic set_reg(input int i,
                         input logic [15:0] v);
    reg_flat[i*16 +: 16] = v;
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm,
                           input int budget,
                           output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      @(negedge clock);
      cyc++;
      seen = frame_done;
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
    @(negedge clock);
    chk({nm, "_fd_pulse"}, frame_done, 0);
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  int x0, fd0, cyc;

  initial begin
    // Reset state
    #12;
    chk("rst_valid", char_valid, 0);
    chk("rst_code", char_code, 0);
    chk("rst_col", char_col, 0);
    chk("rst_row", char_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    @(posedge clock);
    #1 resetn = 1'b1;

    // Full first pass
    set_reg(0, 16'h1A2B);
    push_codes(3'd0, '{52, 0, 53, 63, 1, 10, 2, 11});
    for (int r = 1; r < 8; r++) push_line(3'(r), 16'h0000);
    x0 = n_xfer;
    fd0 = n_fd;
    pulse_start();
    chk("lat_busy", busy, 1);
    chk("lat_scan", char_valid, 0);
    @(posedge clock);
    #1;
    chk("lat_valid", char_valid, 1);
    wait_done("p1", 500, cyc);
    chk("p1_xfers", n_xfer - x0, 64);
    chk("p1_fd_count", n_fd - fd0, 1);

    // Nothing changed: all rows skipped
    x0 = n_xfer;
    pulse_start();
    wait_done("p2", 50, cyc);
    chk("p2_fd_latency", cyc, 9);
    chk("p2_xfers", n_xfer - x0, 0);

    // Only R5 changed
    set_reg(5, 16'hFFFF);
    push_codes(3'd5, '{52, 5, 53, 63, 15, 15, 15, 15});
    x0 = n_xfer;
    pulse_start();
    wait_done("p3", 100, cyc);
    chk("p3_xfers", n_xfer - x0, 8);

    // R3 changes mid-pass: snapshot value is drawn
    set_reg(3, 16'h3333);
    set_reg(6, 16'h6666);
    push_line(3'd3, 16'h3333);
    push_line(3'd6, 16'h6666);
    x0 = n_xfer;
    pulse_start();
    set_reg(3, 16'hBEEF);
    wait_done("p4", 200, cyc);
    chk("p4_xfers", n_xfer - x0, 16);
    push_line(3'd3, 16'hBEEF);
    x0 = n_xfer;
    pulse_start();
    wait_done("p5", 100, cyc);
    chk("p5_xfers", n_xfer - x0, 8);

    // Reset restores first_pass; full redraw under backpressure
    @(posedge clock);
    #1 resetn = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    push_line(3'd0, 16'h1A2B);
    push_line(3'd1, 16'h0000);
    push_line(3'd2, 16'h0000);
    push_line(3'd3, 16'hBEEF);
    push_line(3'd4, 16'h0000);
    push_line(3'd5, 16'hFFFF);
    push_line(3'd6, 16'h6666);
    push_line(3'd7, 16'h0000);
    x0 = n_xfer;
    bp_en = 1'b1;
    pulse_start();
    wait_done("p6", 2000, cyc);
    chk("p6_xfers", n_xfer - x0, 64);
    bp_en = 1'b0;
    @(posedge clock);
    #1 char_ready = 1'b1;

    // Reset in the middle of row 4
    set_reg(4, 16'h4444);
    push_line(3'd4, 16'h4444);
    pulse_start();
    cyc = 0;
    while (!(char_valid && char_row == 3'd4 &&
             char_col == 5'd3) && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    chk("p7_reach_row4", char_row, 4);
    #1 resetn = 1'b0;
    #1;
    chk("p7_async_valid", char_valid, 0);
    chk("p7_async_busy", busy, 0);
    chk("p7_async_row", char_row, 0);
    exp_q.delete();
    @(posedge clock);
    #1 resetn = 1'b1;
    push_line(3'd0, 16'h1A2B);
    push_line(3'd1, 16'h0000);
    push_line(3'd2, 16'h0000);
    push_line(3'd3, 16'hBEEF);
    push_line(3'd4, 16'h4444);
    push_line(3'd5, 16'hFFFF);
    push_line(3'd6, 16'h6666);
    push_line(3'd7, 16'h0000);
    x0 = n_xfer;
    fd0 = n_fd;
    pulse_start();
    repeat (3) pulse_start();
    wait_done("p8", 500, cyc);
    repeat (12) @(negedge clock);
    chk("p8_xfers", n_xfer - x0, 64);
    chk("p8_fd_count", n_fd - fd0, 1);
    chk("p8_no_queued_start", busy, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
